mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory arbiter: default parameter values,
//   the arbiter FSM state encoding, the grant_id owner codes and the bit
//   positions of the one-hot winner vector produced by mem_arb_pick.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF       = 16;
    localparam int DATA_W_DEF       = 16;
    localparam int WAIT_CYCLES_DEF  = 1;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Owner codes driven on grant_id.
    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_IF   = 2'd1;
    localparam logic [1:0] ID_DM   = 2'd2;
    localparam logic [1:0] ID_LD   = 2'd3;

    // Bit positions inside the one-hot winner vector.
    localparam int PICK_IF = 0;
    localparam int PICK_DM = 1;
    localparam int PICK_LD = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational priority selector for the memory arbiter.
//   Ports:
//     if_req, dm_req, ld_req  requests from fetch, load/store and loader
//     ld_starved              loader has been denied STARVE_LIMIT times
//     win[2:0]                one-hot winner (PICK_IF / PICK_DM / PICK_LD),
//                             all zero when nobody requests
//   Normal order is dm > if > ld; a starved loader jumps to the front.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       ld_req,
    input  logic       ld_starved,
    output logic [2:0] win
);

    always_comb begin
        // NOTE: assigning a default before any branch keeps this block purely
        // combinational; a path that skipped the assignment would infer a latch.
        win = '0;
        if (ld_req && ld_starved) begin
            win[PICK_LD] = 1'b1;
        end else if (dm_req) begin
            win[PICK_DM] = 1'b1;
        end else if (if_req) begin
            win[PICK_IF] = 1'b1;
        end else if (ld_req) begin
            win[PICK_LD] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Three-port arbiter in front of a single-port memory.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     if_req/if_addr                instruction fetch (read only)
//     dm_req/dm_we/dm_addr/dm_wdata load/store port
//     ld_req/ld_we/ld_addr/ld_wdata program loader port
//     if_ack, dm_ack, ld_ack        one-cycle completion pulse per port
//     rdata                         read data, valid in the ack cycle
//     if_stall, dm_stall            request pending and not yet acked
//     mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory interface
//     grant_id                      current owner (0 none, 1 if, 2 dm, 3 ld)
//   Each transaction: IDLE (sample + latch winner) -> ACCESS for
//   WAIT_CYCLES+1 cycles with mem_en high -> RESP (ack) -> IDLE.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int WAIT_CYCLES  = WAIT_CYCLES_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              if_ack,
    output logic              dm_ack,
    output logic              ld_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              if_stall,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant_id
);

    localparam int WAIT_W   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(WAIT_CYCLES);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [STARVE_W-1:0] starve_cnt;

    logic [2:0]          win;
    logic [1:0]          sel_id;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .ld_req     (ld_req),
        .ld_starved (starve_cnt == STARVE_MAX),
        .win        (win)
    );

    // Fields of the current winner; only consumed in IDLE.
    always_comb begin
        sel_id    = ID_NONE;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (win[PICK_DM]) begin
            sel_id    = ID_DM;
            sel_we    = dm_we;
            sel_addr  = dm_addr;
            sel_wdata = dm_wdata;
        end else if (win[PICK_IF]) begin
            // Fetch is read only: we is forced low regardless of other ports.
            sel_id    = ID_IF;
            sel_addr  = if_addr;
        end else if (win[PICK_LD]) begin
            sel_id    = ID_LD;
            sel_we    = ld_we;
            sel_addr  = ld_addr;
            sel_wdata = ld_wdata;
        end
    end

    // Acks are registered, so the stall outputs drop in the ack cycle itself.
    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values and simulation matches the flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            rdata      <= '0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            ld_ack     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            grant_id   <= ID_NONE;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            ld_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|win) begin
                        state     <= ST_ACCESS;
                        wait_cnt  <= '0;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        grant_id  <= sel_id;
                        // Loader denial bookkeeping: clear on its own grant,
                        // otherwise count (saturating) while it is waiting.
                        if (win[PICK_LD]) begin
                            starve_cnt <= '0;
                        end else if (ld_req && (starve_cnt != STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state  <= ST_RESP;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (!mem_we) begin
                            rdata <= mem_rdata;
                        end
                        case (grant_id)
                            ID_IF:   if_ack <= 1'b1;
                            ID_DM:   dm_ack <= 1'b1;
                            ID_LD:   ld_ack <= 1'b1;
                            default: ;
                        endcase
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                    grant_id <= ID_NONE;
                end
                default: begin
                    state    <= ST_IDLE;
                    grant_id <= ID_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int WAITC = 1;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, dm_req = 1'b0, ld_req = 1'b0;
    logic          dm_we = 1'b0, ld_we = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0, ld_addr = '0;
    logic [DW-1:0] dm_wdata = '0, ld_wdata = '0;
    logic          if_ack, dm_ack, ld_ack, if_stall, dm_stall;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, rdata;
    logic [1:0]    grant_id;

    // Second instance built with zero wait states.
    logic          w0_rst = 1'b1;
    logic          w0_if_req = 1'b0;
    logic [AW-1:0] w0_if_addr = 16'h0040;
    logic          w0_zero = 1'b0;
    logic [AW-1:0] w0_zaddr = '0;
    logic [DW-1:0] w0_zdata = '0;
    logic [DW-1:0] w0_mem_rdata = 16'h5A5A;
    logic          w0_if_ack, w0_dm_ack, w0_ld_ack, w0_if_stall, w0_dm_stall;
    logic          w0_mem_en, w0_mem_we;
    logic [AW-1:0] w0_mem_addr;
    logic [DW-1:0] w0_mem_wdata, w0_rdata;
    logic [1:0]    w0_grant_id;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAITC), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .if_ack(if_ack), .dm_ack(dm_ack), .ld_ack(ld_ack), .rdata(rdata),
        .if_stall(if_stall), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant_id(grant_id)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0), .STARVE_LIMIT(LIMIT)) dut_w0 (
        .clk(clk), .rst(w0_rst),
        .if_req(w0_if_req), .if_addr(w0_if_addr),
        .dm_req(w0_zero), .dm_we(w0_zero), .dm_addr(w0_zaddr), .dm_wdata(w0_zdata),
        .ld_req(w0_zero), .ld_we(w0_zero), .ld_addr(w0_zaddr), .ld_wdata(w0_zdata),
        .if_ack(w0_if_ack), .dm_ack(w0_dm_ack), .ld_ack(w0_ld_ack), .rdata(w0_rdata),
        .if_stall(w0_if_stall), .dm_stall(w0_dm_stall),
        .mem_en(w0_mem_en), .mem_we(w0_mem_we), .mem_addr(w0_mem_addr), .mem_wdata(w0_mem_wdata),
        .mem_rdata(w0_mem_rdata), .grant_id(w0_grant_id)
    );

    always #5 clk = ~clk;

    // Memory behind the DUT: combinational read, write on every enabled edge.
    logic [DW-1:0] resp_mem [0:255];
    assign mem_rdata = resp_mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_en && mem_we) resp_mem[mem_addr[7:0]] <= mem_wdata;
    end

    // Reference memory contents as seen by the transaction-level model.
    logic [DW-1:0] model_mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) begin
            resp_mem[i]  <= DW'(i * 257) ^ 16'h3C3C;
            model_mem[i]  = DW'(i * 257) ^ 16'h3C3C;
        end
        resp_mem[16] <= 16'hBEEF;
        model_mem[16] = 16'hBEEF;
    end

    typedef struct {
        logic [1:0]    port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            start;
        int            ack_at;
    } txn_t;

    txn_t sb[$];
    int   cyc = 0;
    int   next_free = 0;
    int   starve = 0;
    logic [DW-1:0] last_rd = '0;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one transaction at a time, winner chosen by the
    // priority rule, ack due WAIT+2 cycles after the sampling cycle.
    always @(posedge clk) begin
        int t;
        txn_t x;
        logic [1:0] w;
        t = cyc;
        if (rst) begin
            sb.delete();
            next_free = t + 1;
            starve = 0;
            last_rd = '0;
        end else if (t >= next_free && (if_req || dm_req || ld_req)) begin
            if (ld_req && starve == LIMIT) w = ID_LD;
            else if (dm_req)               w = ID_DM;
            else if (if_req)               w = ID_IF;
            else                           w = ID_LD;
            if (w == ID_LD) starve = 0;
            else if (ld_req && starve < LIMIT) starve++;
            x.port  = w;
            x.we    = (w == ID_DM) ? dm_we : (w == ID_LD) ? ld_we : 1'b0;
            x.addr  = (w == ID_DM) ? dm_addr : (w == ID_LD) ? ld_addr : if_addr;
            x.wdata = (w == ID_DM) ? dm_wdata : (w == ID_LD) ? ld_wdata : '0;
            if (x.we) model_mem[x.addr[7:0]] = x.wdata;
            else      last_rd = model_mem[x.addr[7:0]];
            x.rdata  = last_rd;
            x.start  = t + 1;
            x.ack_at = t + WAITC + 2;
            sb.push_back(x);
            next_free = t + WAITC + 3;
        end
        cyc = t + 1;
    end

    // Monitor: compares every cycle against the in-flight expected transaction.
    always @(negedge clk) begin
        txn_t f;
        bit in_acc, is_ack;
        logic [2:0] exp_ack;
        logic [1:0] exp_gid;
        if (mon_en) begin
            in_acc = 1'b0; is_ack = 1'b0; exp_ack = '0; exp_gid = ID_NONE;
            if (sb.size() > 0) begin
                f = sb[0];
                in_acc = (cyc >= f.start) && (cyc <= f.start + WAITC);
                is_ack = (cyc == f.ack_at);
                if (in_acc || is_ack) exp_gid = f.port;
                if (is_ack) exp_ack = 3'b001 << (f.port - 2'd1);
            end
            check("mem_en", mem_en, in_acc);
            if (in_acc) begin
                check("mem_we", mem_we, f.we);
                check("mem_addr", mem_addr, f.addr);
                if (f.we) check("mem_wdata", mem_wdata, f.wdata);
            end
            check("grant_id", grant_id, exp_gid);
            check("acks", {ld_ack, dm_ack, if_ack}, exp_ack);
            check("if_stall", if_stall, if_req & ~exp_ack[0]);
            check("dm_stall", dm_stall, dm_req & ~exp_ack[1]);
            if (is_ack) begin
                check("rdata", rdata, f.rdata);
                void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        if_req = 1'b0; dm_req = 1'b0; ld_req = 1'b0;
        repeat (6) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n_dm, n, last_ack, n_ack, en_cnt;
        bit got;

        // Reset state
        @(posedge clk); #1; mon_en = 1'b1;
        check("rst_grant_id", grant_id, ID_NONE);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_mem_addr", mem_addr, 16'h0000);
        step(); rst = 1'b0;
        step();

        // Single fetch at 0x0010 returning 0xBEEF
        if_req = 1'b1; if_addr = 16'h0010;
        repeat (3) step();
        if_req = 1'b0;
        @(negedge clk);
        check("fetch_ack_c3", if_ack, 1'b1);
        check("fetch_rdata_c3", rdata, 16'hBEEF);
        drain();

        // Simultaneous fetch and dm write: dm first, fetch acked in cycle 7
        if_req = 1'b1; if_addr = 16'h0020;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
        repeat (3) step();
        dm_req = 1'b0; dm_we = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("fetch_after_dm_ack_c7", if_ack, 1'b1);
        check("fetch_reads_dm_write", rdata, 16'h1234);
        step(); if_req = 1'b0;
        drain();

        // dm read dropped in cycle 1 still completes
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0010;
        step(); dm_req = 1'b0;
        step();
        @(negedge clk);
        check("dropped_req_mem_en_c2", mem_en, 1'b1);
        step();
        @(negedge clk);
        check("dropped_req_ack_c3", dm_ack, 1'b1);
        drain();

        // Loader starvation: four dm grants, then ld, twice in a row
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0011;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0012;
        for (int pass = 0; pass < 2; pass++) begin
            n_dm = 0; got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (dm_ack) n_dm++;
                if (ld_ack) got = 1'b1;
            end
            check("starve_ld_granted", got, 1'b1);
            check("starve_dm_grants", n_dm, 4);
        end
        step();
        drain();

        // Randomized traffic on all three ports
        for (int i = 0; i < 1500; i++) begin
            if_req   = ($urandom_range(0, 99) < 45);
            if_addr  = AW'($urandom_range(0, 31));
            dm_req   = ($urandom_range(0, 99) < 55);
            dm_we    = 1'($urandom_range(0, 1));
            dm_addr  = AW'($urandom_range(0, 31));
            dm_wdata = DW'($urandom);
            ld_req   = ($urandom_range(0, 99) < 40);
            ld_we    = 1'($urandom_range(0, 1));
            ld_addr  = AW'($urandom_range(0, 31));
            ld_wdata = DW'($urandom);
            step();
        end
        drain();

        // Reset in cycle 2 of a dm write abandons it
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0005; dm_wdata = 16'hAAAA;
        step(); dm_req = 1'b0; dm_we = 1'b0;
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        check("rst_mid_mem_en", mem_en, 1'b0);
        check("rst_mid_mem_we", mem_we, 1'b0);
        check("rst_mid_mem_addr", mem_addr, 16'h0000);
        check("rst_mid_mem_wdata", mem_wdata, 16'h0000);
        check("rst_mid_grant_id", grant_id, ID_NONE);
        check("rst_mid_rdata", rdata, 16'h0000);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (dm_ack) n++;
        end
        check("rst_mid_no_dm_ack", n, 0);
        check("scoreboard_drained", sb.size(), 0);

        // Zero wait states: held fetch acked every 3 cycles, 1 mem_en cycle each
        step(); w0_rst = 1'b0;
        step(); w0_if_req = 1'b1;
        last_ack = -1; n_ack = 0; en_cnt = 0;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            if (w0_mem_en) en_cnt++;
            if (w0_if_ack) begin
                if (last_ack < 0) check("w0_first_ack", i, 2);
                else              check("w0_ack_gap", i - last_ack, 3);
                check("w0_mem_en_cycles", en_cnt, 1);
                check("w0_rdata", w0_rdata, 16'h5A5A);
                en_cnt = 0;
                last_ack = i;
                n_ack++;
            end
        end
        check("w0_ack_count", n_ack, 10);
        w0_if_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
